// File: rtl/udp_tx_scheduler_pkg.sv
// Shared types for the UDP transmit scheduler: FSM states, one-hot grant codes, saturating counter helper.
package udp_tx_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_A    = 2'b01;
    localparam logic [1:0] GRANT_S    = 2'b10;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/udp_tx_sched_timer.sv
// Loadable down-counter with zero flag; load wins over count, holds at zero. No backpressure.
module udp_tx_sched_timer #(
    parameter int W = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/udp_tx_scheduler.sv
// Arbitrates audio/status packets onto one UDP port; 1-cycle grant latency, holds valid until done or timeout.
// Requesters hold valid until their ready pulse; the core is only ever offered one latched packet.
module udp_tx_scheduler
    import udp_tx_scheduler_pkg::*;
#(
    parameter int DATA_W          = 7680,
    parameter int LEN_W           = 16,
    parameter int TIMEOUT_CYC     = 1_000_000,
    parameter int GAP_CYC         = 16,
    parameter int MAX_AUDIO_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req_valid,
    input  logic [DATA_W-1:0] a_req_data,
    input  logic [LEN_W-1:0]  a_req_len,
    output logic              a_req_ready,
    input  logic              s_req_valid,
    input  logic [DATA_W-1:0] s_req_data,
    input  logic [LEN_W-1:0]  s_req_len,
    output logic              s_req_ready,
    output logic              udp_send_data_valid,
    output logic [DATA_W-1:0] udp_send_data,
    output logic [LEN_W-1:0]  udp_send_data_length,
    input  logic              udp_send_done,
    output logic [1:0]        grant,
    output logic              drop_pulse,
    output logic [7:0]        timeout_cnt
);

    localparam int          GAP_EFF = (GAP_CYC < 1) ? 1 : GAP_CYC;
    localparam int          TMR_MAX = (TIMEOUT_CYC > GAP_EFF) ? TIMEOUT_CYC : GAP_EFF;
    localparam int          TMR_W   = $clog2(TMR_MAX + 1);
    localparam int          BURST_W = $clog2(MAX_AUDIO_BURST + 1);
    localparam logic [31:0] MAX_LEN = 32'(DATA_W / 8);

    state_t              state_q, state_d;
    logic [BURST_W-1:0]  burst_q, burst_d;
    logic [7:0]          tcnt_q, tcnt_d;
    logic [1:0]          grant_q, grant_d;
    logic [DATA_W-1:0]   data_q;
    logic [LEN_W-1:0]    len_q;
    logic                a_rdy_q, a_rdy_d;
    logic                s_rdy_q, s_rdy_d;
    logic                drop_q, drop_d;
    logic                latch_en;
    logic                tmr_load;
    logic [TMR_W-1:0]    tmr_val;
    logic                tmr_zero;

    // While a reject's ready pulse is out the requester may still hold valid; skip that cycle.
    logic               req_vld;
    logic               pick_s;
    logic [LEN_W-1:0]   win_len;
    logic               len_ok;
    logic               finish;

    assign req_vld = (a_req_valid | s_req_valid) & ~(a_rdy_q | s_rdy_q);
    assign pick_s  = s_req_valid & (~a_req_valid | (burst_q == BURST_W'(MAX_AUDIO_BURST)));
    assign win_len = pick_s ? s_req_len : a_req_len;
    assign len_ok  = (win_len != '0) && (32'(win_len) <= MAX_LEN);
    assign finish  = (state_q == ST_SEND) & (udp_send_done | tmr_zero);

    udp_tx_sched_timer #(.W(TMR_W)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (req_vld && len_ok) state_d = ST_SEND;
            ST_SEND: if (finish)            state_d = ST_GAP;
            ST_GAP:  if (tmr_zero)          state_d = ST_IDLE;
            default:                        state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        latch_en = 1'b0;
        grant_d  = grant_q;
        a_rdy_d  = 1'b0;
        s_rdy_d  = 1'b0;
        drop_d   = 1'b0;
        burst_d  = burst_q;
        tcnt_d   = tcnt_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (req_vld) begin
                    if (len_ok) begin
                        latch_en = 1'b1;
                        grant_d  = pick_s ? GRANT_S : GRANT_A;
                        burst_d  = (pick_s || !s_req_valid) ? '0 : burst_q + BURST_W'(1);
                        tmr_load = 1'b1;
                        tmr_val  = TMR_W'(TIMEOUT_CYC - 1);
                    end else begin
                        a_rdy_d = ~pick_s;
                        s_rdy_d = pick_s;
                        drop_d  = 1'b1;
                    end
                end
            end
            ST_SEND: begin
                if (finish) begin
                    grant_d  = GRANT_NONE;
                    a_rdy_d  = (grant_q == GRANT_A);
                    s_rdy_d  = (grant_q == GRANT_S);
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(GAP_EFF - 1);
                    // done in the expiry cycle still counts as a clean send
                    if (!udp_send_done) begin
                        drop_d = 1'b1;
                        tcnt_d = sat_inc8(tcnt_q);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            burst_q <= '0;
            tcnt_q  <= '0;
            grant_q <= GRANT_NONE;
            data_q  <= '0;
            len_q   <= '0;
            a_rdy_q <= 1'b0;
            s_rdy_q <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            burst_q <= burst_d;
            tcnt_q  <= tcnt_d;
            grant_q <= grant_d;
            a_rdy_q <= a_rdy_d;
            s_rdy_q <= s_rdy_d;
            drop_q  <= drop_d;
            if (latch_en) begin
                data_q <= pick_s ? s_req_data : a_req_data;
                len_q  <= win_len;
            end
        end
    end

    assign udp_send_data_valid  = (state_q == ST_SEND);
    assign udp_send_data        = data_q;
    assign udp_send_data_length = len_q;
    assign grant                = grant_q;
    assign a_req_ready          = a_rdy_q;
    assign s_req_ready          = s_rdy_q;
    assign drop_pulse           = drop_q;
    assign timeout_cnt          = tcnt_q;

endmodule

// File: tb/tb_udp_tx_scheduler.sv
// Scoreboard bench for udp_tx_scheduler with small timeout/gap/burst parameters.
module tb_udp_tx_scheduler;

    localparam int DW  = 64;
    localparam int LW  = 16;
    localparam int TO  = 100;
    localparam int GAP = 4;
    localparam int MB  = 2;

    localparam logic [1:0] GA = 2'b01;
    localparam logic [1:0] GS = 2'b10;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_vld, s_vld, a_rdy, s_rdy;
    logic [DW-1:0] a_dat, s_dat, tx_dat;
    logic [LW-1:0] a_len, s_len, tx_len;
    logic          tx_vld, tx_done, drop;
    logic [1:0]    grant;
    logic [7:0]    tcnt;

    always #5 clk = ~clk;

    udp_tx_scheduler #(
        .DATA_W(DW), .LEN_W(LW), .TIMEOUT_CYC(TO), .GAP_CYC(GAP), .MAX_AUDIO_BURST(MB)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .a_req_valid          (a_vld),
        .a_req_data           (a_dat),
        .a_req_len            (a_len),
        .a_req_ready          (a_rdy),
        .s_req_valid          (s_vld),
        .s_req_data           (s_dat),
        .s_req_len            (s_len),
        .s_req_ready          (s_rdy),
        .udp_send_data_valid  (tx_vld),
        .udp_send_data        (tx_dat),
        .udp_send_data_length (tx_len),
        .udp_send_done        (tx_done),
        .grant                (grant),
        .drop_pulse           (drop),
        .timeout_cnt          (tcnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [1:0]    g;
        logic [DW-1:0] d;
        logic [LW-1:0] l;
    } exp_t;

    exp_t exp_q[$];
    int   a_rdy_cnt = 0;
    int   s_rdy_cnt = 0;
    logic vld_prev  = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic push(input logic [1:0] g, input logic [DW-1:0] d, input logic [LW-1:0] l);
        exp_t e;
        e.g = g;
        e.d = d;
        e.l = l;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_vld(input string tag);
        int n = 0;
        while (tx_vld !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (tx_vld !== 1'b1) check(tag, 64'd0, 64'd1);
    endtask

    task automatic wait_rdy(input string tag);
        int n = 1;
        @(negedge clk);
        while (a_rdy !== 1'b1 && s_rdy !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (a_rdy !== 1'b1 && s_rdy !== 1'b1) check(tag, 64'd0, 64'd1);
    endtask

    task automatic pulse_done();
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    // Scoreboard side: every new packet presented to the core must match the next expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (a_rdy === 1'b1) a_rdy_cnt++;
        if (s_rdy === 1'b1) s_rdy_cnt++;
        if (tx_vld === 1'b1 && vld_prev !== 1'b1) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_pkt", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("sb_grant", 64'(grant), 64'(e.g));
                check("sb_len", 64'(tx_len), 64'(e.l));
                check("sb_data", tx_dat, e.d);
            end
        end
        vld_prev = tx_vld;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int r0, r1, gap, c;
        logic [1:0] order [6];

        rst = 1'b1; a_vld = 1'b0; s_vld = 1'b0; tx_done = 1'b0;
        a_dat = '0; s_dat = '0; a_len = '0; s_len = '0;
        tick(3);
        check("rst_valid", 64'(tx_vld), 64'd0);
        check("rst_grant", 64'(grant), 64'd0);
        check("rst_a_ready", 64'(a_rdy), 64'd0);
        check("rst_s_ready", 64'(s_rdy), 64'd0);
        check("rst_drop", 64'(drop), 64'd0);
        check("rst_tcnt", 64'(tcnt), 64'd0);
        rst = 1'b0;
        tick(1);

        // single audio packet, done 10 cycles after valid, then gap to the next packet
        a_dat = 64'h1111_2222_3333_4444; a_len = 16'd8; a_vld = 1'b1;
        push(GA, a_dat, a_len);
        r0 = a_rdy_cnt;
        tick(1);
        check("t1_latency_vld", 64'(tx_vld), 64'd1);
        check("t1_grant", 64'(grant), 64'(GA));
        tick(9);
        check("t1_hold_vld", 64'(tx_vld), 64'd1);
        pulse_done();
        check("t1_vld_low", 64'(tx_vld), 64'd0);
        check("t1_a_ready", 64'(a_rdy), 64'd1);
        check("t1_grant_idle", 64'(grant), 64'd0);
        check("t1_no_drop", 64'(drop), 64'd0);
        a_dat = 64'h5555_6666_7777_8888;
        push(GA, a_dat, a_len);
        gap = 0;
        while (tx_vld !== 1'b1 && gap < 50) begin
            gap++;
            tick(1);
        end
        // GAP cycles plus the IDLE arbitration cycle
        check("t1_gap_low_cycles", 64'(gap), 64'(GAP + 1));
        tick(2);
        pulse_done();
        a_vld = 1'b0;
        check("t1_a_ready2", 64'(a_rdy), 64'd1);
        tick(1);
        check("t1_ready_pulses", 64'(a_rdy_cnt - r0), 64'd2);
        check("t1_no_s_ready", 64'(s_rdy_cnt), 64'd0);
        tick(6);

        // both sources continuously requesting: A,A,S,A,A,S
        order[0] = GA; order[1] = GA; order[2] = GS;
        order[3] = GA; order[4] = GA; order[5] = GS;
        a_dat = 64'hA0; s_dat = 64'h50; a_len = 16'd8; s_len = 16'd4;
        push(GA, 64'hA0, 16'd8); push(GA, 64'hA1, 16'd8); push(GS, 64'h50, 16'd4);
        push(GA, 64'hA2, 16'd8); push(GA, 64'hA3, 16'd8); push(GS, 64'h51, 16'd4);
        a_vld = 1'b1; s_vld = 1'b1;
        for (int k = 0; k < 6; k++) begin
            wait_vld("t2_wait_vld");
            tick(4);
            pulse_done();
            check("t2_ready_owner", 64'({s_rdy, a_rdy}), 64'(order[k]));
            if (a_rdy === 1'b1) a_dat = a_dat + 1;
            if (s_rdy === 1'b1) s_dat = s_dat + 1;
        end
        a_vld = 1'b0; s_vld = 1'b0;
        tick(6);

        // rejected lengths: 0 and one above the bus size
        r1 = s_rdy_cnt;
        s_dat = 64'h0BAD; s_len = 16'd0; s_vld = 1'b1;
        tick(1);
        check("t4_len0_s_ready", 64'(s_rdy), 64'd1);
        check("t4_len0_drop", 64'(drop), 64'd1);
        check("t4_len0_no_vld", 64'(tx_vld), 64'd0);
        s_vld = 1'b0;
        tick(1);
        check("t4_len0_drop_width", 64'(drop), 64'd0);
        tick(2);
        s_len = 16'd9; s_vld = 1'b1;
        tick(1);
        check("t4_len9_s_ready", 64'(s_rdy), 64'd1);
        check("t4_len9_drop", 64'(drop), 64'd1);
        check("t4_len9_no_vld", 64'(tx_vld), 64'd0);
        s_vld = 1'b0;
        tick(3);
        check("t4_ready_count", 64'(s_rdy_cnt - r1), 64'd2);
        check("t4_tcnt", 64'(tcnt), 64'd0);

        // done in the same cycle the timeout expires
        a_dat = 64'hC0C0; a_len = 16'd8; a_vld = 1'b1;
        push(GA, a_dat, a_len);
        wait_vld("t5_wait_vld");
        tick(TO - 1);
        check("t5_vld_at_limit", 64'(tx_vld), 64'd1);
        pulse_done();
        a_vld = 1'b0;
        check("t5_vld_low", 64'(tx_vld), 64'd0);
        check("t5_a_ready", 64'(a_rdy), 64'd1);
        check("t5_no_drop", 64'(drop), 64'd0);
        check("t5_tcnt", 64'(tcnt), 64'd0);
        tick(6);

        // timeout abort, then repeated aborts to saturate the counter
        a_dat = 64'hDEAD; a_vld = 1'b1;
        push(GA, a_dat, a_len);
        wait_vld("t3_wait_vld");
        c = 1;
        while (tx_vld === 1'b1 && c < 300) begin
            tick(1);
            if (tx_vld === 1'b1) c++;
        end
        check("t3_valid_cycles", 64'(c), 64'(TO));
        check("t3_drop", 64'(drop), 64'd1);
        check("t3_a_ready", 64'(a_rdy), 64'd1);
        check("t3_tcnt1", 64'(tcnt), 64'd1);
        for (int i = 0; i < 255; i++) begin
            push(GA, a_dat, a_len);
            wait_rdy("t3_wait_rdy");
        end
        a_vld = 1'b0;
        check("t3_tcnt_sat", 64'(tcnt), 64'd255);
        tick(6);

        // reset three cycles into SEND
        a_dat = 64'hBEEF; a_vld = 1'b1;
        push(GA, a_dat, a_len);
        wait_vld("t6_wait_vld");
        tick(2);
        r0 = a_rdy_cnt;
        rst = 1'b1;
        tick(1);
        check("t6_vld_low", 64'(tx_vld), 64'd0);
        check("t6_grant", 64'(grant), 64'd0);
        check("t6_no_ready", 64'(a_rdy), 64'd0);
        check("t6_no_drop", 64'(drop), 64'd0);
        check("t6_tcnt", 64'(tcnt), 64'd0);
        rst = 1'b0;
        a_dat = 64'hF00D;
        push(GA, a_dat, a_len);
        wait_vld("t6_wait_vld2");
        check("t6_new_grant", 64'(grant), 64'(GA));
        tick(3);
        pulse_done();
        a_vld = 1'b0;
        check("t6_a_ready", 64'(a_rdy), 64'd1);
        tick(2);
        check("t6_ready_count", 64'(a_rdy_cnt - r0), 64'd1);

        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
